// File: rtl/riscv_fetch_unit.sv
// rtl/riscv_fetch_unit.sv - instruction fetch stage with prefetch FIFO and redirect handling
//
// Sequences fetch addresses, issues one outstanding request at a time to a
// variable-latency instruction memory, buffers returned words with their PC
// in a prefetch FIFO, and restarts the stream on redirect.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   - a redirect with redirect_pc[1:0] != 0 enters HALT and delivers
//               one fault entry (inst_fault=1, inst_pc=redirect_pc unmodified)
//   undefined - redirect low bits are cleared and inst_fault is tied 0
//
// Ports:
//   clk, resetn                          clock, synchronous active-low reset
//   imem_req_valid/ready, imem_addr      fetch request channel
//   imem_rsp_valid, imem_rdata           in-order response channel
//   inst_valid/ready, inst_data/pc/fault decode-side FIFO head
//   redirect_valid, redirect_pc          flush and restart fetch
module riscv_fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            resetn,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;

    logic [31:0]     mem_data_q [FIFO_DEPTH];
    logic [31:0]     mem_data_d [FIFO_DEPTH];
    logic [XLEN-1:0] mem_pc_q   [FIFO_DEPTH];
    logic [XLEN-1:0] mem_pc_d   [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic            fifo_full;
    logic            push;
    logic            pop;
    logic            in_flight;
    logic [31:0]     push_data;
    logic [XLEN-1:0] push_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic mem_fault_q [FIFO_DEPTH];
    logic mem_fault_d [FIFO_DEPTH];
    logic push_fault;
    // drop_q: a response is still owed to us while sitting in HALT
    logic drop_q, drop_d;
    logic fault_pend_q, fault_pend_d;
`endif

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign imem_addr  = fetch_pc_q;
    assign inst_valid = (count_q != '0);
    assign inst_data  = mem_data_q[rd_ptr_q];
    assign inst_pc    = mem_pc_q[rd_ptr_q];
`ifdef FETCH_MISALIGN_TRAP_EN
    assign inst_fault = mem_fault_q[rd_ptr_q];
`else
    assign inst_fault = 1'b0;
`endif

    // Fetch sequencing
    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        req_pc_d       = req_pc_q;
        imem_req_valid = 1'b0;
        push           = 1'b0;
        push_data      = imem_rdata;
        push_pc        = req_pc_q;
        in_flight      = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        push_fault     = 1'b0;
        drop_d         = drop_q;
        fault_pend_d   = fault_pend_q;
`endif

        case (state_q)
            ST_REQ: begin
                // Issue only when the response is guaranteed a FIFO slot
                imem_req_valid = resetn && !fifo_full && !redirect_valid;
                if (imem_req_valid && imem_req_ready) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    push    = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem_rsp_valid) begin
                    state_d = ST_REQ;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_HALT: begin
                if (drop_q && imem_rsp_valid) begin
                    drop_d = 1'b0;
                end
                if (fault_pend_q && !fifo_full) begin
                    push         = 1'b1;
                    push_data    = '0;
                    push_pc      = fetch_pc_q;
                    push_fault   = 1'b1;
                    fault_pend_d = 1'b0;
                end
            end
`endif
            default: state_d = ST_REQ;
        endcase

        // Redirect overrides everything above; a response still owed by
        // memory must be swallowed before the new stream may issue.
        if (redirect_valid) begin
            push       = 1'b0;
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            in_flight  = ((state_q == ST_WAIT) || (state_q == ST_DROP)) && !imem_rsp_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (state_q == ST_HALT) begin
                in_flight = drop_q && !imem_rsp_valid;
            end
            if (redirect_pc[1:0] != 2'b00) begin
                state_d      = ST_HALT;
                fetch_pc_d   = redirect_pc;
                drop_d       = in_flight;
                fault_pend_d = 1'b1;
            end else begin
                state_d      = in_flight ? ST_DROP : ST_REQ;
                drop_d       = 1'b0;
                fault_pend_d = 1'b0;
            end
`else
            state_d = in_flight ? ST_DROP : ST_REQ;
`endif
        end
    end

    // Prefetch FIFO
    always_comb begin
        mem_data_d = mem_data_q;
        mem_pc_d   = mem_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        mem_fault_d = mem_fault_q;
`endif
        pop      = inst_valid && inst_ready && !redirect_valid;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        if (push) begin
            mem_data_d[wr_ptr_q] = push_data;
            mem_pc_d[wr_ptr_q]   = push_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
            mem_fault_d[wr_ptr_q] = push_fault;
`endif
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (redirect_valid) begin
            wr_ptr_d = rd_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            mem_data_q <= '{default: '0};
            mem_pc_q   <= '{default: '0};
`ifdef FETCH_MISALIGN_TRAP_EN
            mem_fault_q  <= '{default: 1'b0};
            drop_q       <= 1'b0;
            fault_pend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_data_q <= mem_data_d;
            mem_pc_q   <= mem_pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            mem_fault_q  <= mem_fault_d;
            drop_q       <= drop_d;
            fault_pend_q <= fault_pend_d;
`endif
        end
    end

endmodule
